dmem_lsu: RTL and testbench

- Load/store unit: the initiator side of the core's data-memory port.
- Accepts one load or store request from the execute stage via a valid/ready handshake.
- Drives the word-only data memory (32-bit address, 32-bit write data, single write enable, combinational read data). Sub-word stores are implemented as read-modify-write.
- Returns extended load data, or a fault flag, on a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/dmem_lsu_if.sv | 28 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/dmem_lsu.sv | 130 +++++++++++++
 tb/tb_dmem_lsu.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM states and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h9600_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_t;

    // Illegal funct3 for the direction, or an access not aligned to its size.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
        logic bad_f3;
        logic misaligned;
        if (we) bad_f3 = (funct3 > F3_W);
        else    bad_f3 = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
        misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                     ((funct3[1:0] == 2'b10) && (lane != 2'b00));
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Bundle of the LSU's request, response and data-memory signals.
// slave = the LSU itself; master = the execute stage plus the memory it drives.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_a, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: extract/extend load data from a memory word and merge
// sub-word store data into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_merge_word,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rd_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];

        o_load_data = i_rd_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rd_word;
        endcase

        o_store_data = i_merge_word;
        case (i_funct3)
            F3_B: o_store_data[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_lane[1]) o_store_data[31:16] = i_wdata[15:0];
                else           o_store_data[15:0]  = i_wdata[15:0];
            end
            default: o_store_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-only data memory; one transaction in flight,
// sub-word stores done as read-modify-write.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int          DMEM_BYTES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    dmem_lsu_if.slave  bus
);

    localparam int WIN_BITS = $clog2(DMEM_BYTES);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [31:0] r_mem_a;

    logic        w_hit;
    logic        w_fault;
    logic [31:0] w_aligned;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;

    assign w_hit     = (bus.req_addr >> WIN_BITS) == (DMEM_BASE >> WIN_BITS);
    assign w_fault   = !w_hit || access_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign w_aligned = {r_addr[31:2], 2'b00};

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_fault = r_fault;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_lane       (r_addr[1:0]),
        .i_rd_word    (bus.mem_rd),
        .i_wdata      (r_wdata),
        .i_merge_word (r_merge),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_a      = r_mem_a;
        bus.mem_wd     = '0;
        bus.mem_we     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_fault)                  w_next = RESP;
                    else if (!bus.req_we)         w_next = LOAD;
                    else if (bus.req_funct3 == F3_W) w_next = STORE;
                    else                          w_next = RMW_RD;
                end
            end
            LOAD: begin
                bus.mem_a = w_aligned;
                w_next    = RESP;
            end
            STORE: begin
                bus.mem_a = w_aligned;
                if (!reset) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = r_wdata;
                end
                w_next = RESP;
            end
            RMW_RD: begin
                bus.mem_a = w_aligned;
                w_next    = RMW_WR;
            end
            RMW_WR: begin
                bus.mem_a = w_aligned;
                if (!reset) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = w_store_data;
                end
                w_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
            r_mem_a  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state inside {LOAD, STORE, RMW_RD, RMW_WR}) r_mem_a <= w_aligned;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_funct3 <= bus.req_funct3;
                        r_rdata  <= '0;
                        r_fault  <= w_fault;
                    end
                end
                LOAD:    r_rdata <= w_load_data;
                RMW_RD:  r_merge <= bus.mem_rd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: byte-level reference memory model, a per-cycle
// response monitor, and literal expectations for the hand-computed cases.
module tb_dmem_lsu;
    import lsu_pkg::*;

    localparam logic [31:0] BASE = 32'h9600_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu #(.DMEM_BASE(BASE), .DMEM_BYTES(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Word memory seen by the DUT (combinational read, clocked write).
    logic [31:0] dmem [0:255] = '{default: '0};
    logic        pl_en   = 1'b0;
    logic [7:0]  pl_idx  = '0;
    logic [31:0] pl_data = '0;

    assign bus.mem_rd = dmem[bus.mem_a[9:2]];

    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_data;
        else if (bus.mem_we === 1'b1) dmem[bus.mem_a[9:2]] <= bus.mem_wd;
    end

    // Reference model: a plain byte array of the window.
    logic [7:0] ref_mem [0:1023];
    resp_t      exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output resp_t r);
        int          size;
        int          off;
        logic        bad;
        logic [31:0] v;
        off = int'(addr[9:0]);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        bad = ((addr >> 10) != (BASE >> 10));
        if (we) bad = bad || (f3 > 3'd2);
        else    bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (size == 0) bad = 1'b1;
        else if (off % size != 0) bad = 1'b1;
        r.rdata = '0;
        r.fault = bad;
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[off+i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off+i]) << (8*i));
                if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
                r.rdata = v;
            end
        end
    endtask

    // Response monitor: compares the response channel to the model every cycle it is valid.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we !== 1'b1) check("mem_wd_idle", bus.mem_wd, 32'd0);
            if (bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    check("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
                    check("resp_fault", 32'(bus.resp_fault), 32'(exp_q[0].fault));
                    check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1 && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    task automatic preload(input int idx, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[4*idx+i] = d[8*i +: 8];
        @(negedge clk);
        pl_idx  = 8'(idx);
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic fault, output int lat,
                          output int pulses, output logic [31:0] pulse_a,
                          output logic [31:0] pulse_wd, output int acc_wait);
        resp_t e;
        logic  rdy;
        logic  got;
        rdata = '0; fault = 1'b0; lat = 0; pulses = 0;
        pulse_a = '0; pulse_wd = '0; acc_wait = 0; got = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!got && acc_wait < 20) begin
            if (acc_wait > 0) @(negedge clk);
            rdy = bus.req_ready;
            acc_wait++;
            @(posedge clk);
            got = rdy;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wdata, e);
        exp_q.push_back(e);
        #1 bus.req_valid = 1'b0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.mem_we === 1'b1) begin
                pulses++;
                pulse_a  = bus.mem_a;
                pulse_wd = bus.mem_wd;
            end
            if (bus.resp_valid === 1'b1) got = 1'b1;
            else @(posedge clk);
        end
        if (!got) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        rdata = bus.resp_rdata;
        fault = bus.resp_fault;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            check("req_ready_held_low", 32'(bus.req_ready), 32'd0);
            check("resp_valid_held", 32'(bus.resp_valid), 32'd1);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    logic [31:0] rd, pa, pwd;
    logic        flt;
    int          lat, pul, aw;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
    } flt_vec_t;

    flt_vec_t fvec [4] = '{
        '{1'b0, F3_W,  32'h9600_0021},
        '{1'b0, F3_H,  32'h9600_0031},
        '{1'b1, F3_W,  32'h1000_0000},
        '{1'b0, 3'd3,  32'h9600_0010}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        reset          = 1'b1;
        preload(8, 32'h1122_3344);
        @(negedge clk);
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata,      32'd0);
        check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst_mem_a",      bus.mem_a,           32'd0);
        check("rst_mem_wd",     bus.mem_wd,          32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        reset = 1'b0;

        // Word store then load back.
        do_req(1'b1, F3_W, 32'h9600_0010, 32'hDEAD_BEEF, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("sw_lat",    32'(lat), 32'd2);
        check("sw_pulses", 32'(pul), 32'd1);
        check("sw_mem_a",  pa,       32'h9600_0010);
        check("sw_mem_wd", pwd,      32'hDEAD_BEEF);
        check("sw_word",   dmem[4],  32'hDEAD_BEEF);
        do_req(1'b0, F3_W, 32'h9600_0010, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("lw_rdata",  rd,       32'hDEAD_BEEF);
        check("lw_fault",  32'(flt), 32'd0);
        check("lw_lat",    32'(lat), 32'd2);
        check("lw_pulses", 32'(pul), 32'd0);

        // Byte store as read-modify-write, then signed/unsigned byte loads.
        do_req(1'b1, F3_B, 32'h9600_0022, 32'h0000_00AA, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("sb_lat",    32'(lat), 32'd3);
        check("sb_pulses", 32'(pul), 32'd1);
        check("sb_mem_a",  pa,       32'h9600_0020);
        check("sb_word",   dmem[8],  32'h11AA_3344);
        do_req(1'b0, F3_B, 32'h9600_0022, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("lb_rdata",  rd,       32'hFFFF_FFAA);
        do_req(1'b0, F3_BU, 32'h9600_0022, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("lbu_rdata", rd,       32'h0000_00AA);

        // Halfword store into the upper half of a zero word.
        do_req(1'b1, F3_H, 32'h9600_0032, 32'h0000_8001, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("sh_lat",    32'(lat), 32'd3);
        check("sh_word",   dmem[12], 32'h8001_0000);
        do_req(1'b0, F3_H, 32'h9600_0032, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("lh_rdata",  rd,       32'hFFFF_8001);
        do_req(1'b0, F3_HU, 32'h9600_0032, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("lhu_rdata", rd,       32'h0000_8001);

        // Faulting requests: misaligned, out of window, illegal funct3.
        foreach (fvec[i]) begin
            do_req(fvec[i].we, fvec[i].f3, fvec[i].addr, 32'h1234_5678, 0,
                   rd, flt, lat, pul, pa, pwd, aw);
            check("flt_fault",  32'(flt), 32'd1);
            check("flt_rdata",  rd,       32'd0);
            check("flt_lat",    32'(lat), 32'd1);
            check("flt_pulses", 32'(pul), 32'd0);
        end

        // Response back-pressure with a competing request presented meanwhile.
        do_req(1'b0, F3_W, 32'h9600_0010, 32'h0, 5, rd, flt, lat, pul, pa, pwd, aw);
        check("hold_rdata", rd,       32'hDEAD_BEEF);
        check("hold_lat",   32'(lat), 32'd2);
        do_req(1'b0, F3_W, 32'h9600_0010, 32'h0, 0, rd, flt, lat, pul, pa, pwd, aw);
        check("post_hold_accept_wait", 32'(aw), 32'd1);
        check("post_hold_rdata",       rd,      32'hDEAD_BEEF);

        // Reset while an SB is in its write cycle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h9600_0021;
        bus.req_wdata  = 32'h0000_0055;
        check("rst_op_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rmw_wr_we", 32'(bus.mem_we), 32'd1);
        check("rmw_wr_wd", bus.mem_wd,      32'h11AA_5544);
        reset = 1'b1;
        #1 check("we_in_reset", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_ready",      32'(bus.req_ready),  32'd1);
            check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        check("post_rst_word", dmem[8], 32'h11AA_3344);

        for (int w = 0; w < 256; w++) check("mem_vs_model", dmem[w], ref_word(w));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
